// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: configurable data/parity/stop framing, error flags, valid/ready output.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around the bit centre.
module uart_rx_framed #(
  parameter int CLK_FREQ    = 10000000,
  parameter int BAUD_RATE   = 19200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int BAUD_CNT_W  = 10
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 rx_i,
  input  logic                 ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o,
  output logic [2:0]           state_o
);

  localparam int BAUD_DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF     = BAUD_DIV / 2;
  localparam logic [BAUD_CNT_W-1:0] CNT_LAST = BAUD_CNT_W'(BAUD_DIV - 1);
  localparam logic [BAUD_CNT_W-1:0] CNT_HALF = BAUD_CNT_W'(HALF);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       ODD_PAR   = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state;
  logic                  rx_meta;
  logic                  rx_s;
  logic [BAUD_CNT_W-1:0] baud_cnt;
  logic [3:0]            bit_cnt;
  logic                  stop_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_acc;
  logic                  frame_acc;
  logic                  bit_tick;
  logic                  bit_val;
  logic                  wrap;

  assign state_o = state;
  assign wrap    = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [BAUD_CNT_W-1:0] CNT_PRE = BAUD_CNT_W'(HALF - 1);
  localparam logic [BAUD_CNT_W-1:0] CNT_DEC = BAUD_CNT_W'(HALF + 1);
  logic samp_a;
  logic samp_b;

  // Two earlier samples are held; the third is the live rx_s at the decision point.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (state != S_IDLE) begin
      if (baud_cnt == CNT_PRE) samp_a <= rx_s;
      if (baud_cnt == CNT_HALF) samp_b <= rx_s;
    end
  end

  assign bit_tick = (state != S_IDLE) && (baud_cnt == CNT_DEC);
  assign bit_val  = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
`else
  assign bit_tick = (state != S_IDLE) && (baud_cnt == CNT_HALF);
  assign bit_val  = rx_s;
`endif

  // Output handshake: a word transfers on any clock edge where valid_o && ready_i.
  // data_o and the error flags hold steady while valid_o is high; a frame that
  // completes while an unaccepted word is held is dropped and flagged by overrun_o.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= S_IDLE;
      busy_o       <= 1'b0;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      frame_acc    <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (valid_o && ready_i) valid_o <= 1'b0;

      if (state == S_IDLE) baud_cnt <= '0;
      else if (wrap)       baud_cnt <= '0;
      else                 baud_cnt <= baud_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state     <= S_START;
            busy_o    <= 1'b1;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_acc   <= 1'b0;
            frame_acc <= 1'b0;
          end
        end
        S_START: begin
          // A line that is high again at the bit centre was only a glitch.
          if (bit_tick && bit_val) begin
            state    <= S_IDLE;
            busy_o   <= 1'b0;
            baud_cnt <= '0;
          end else if (wrap) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tick) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          if (wrap) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_tick) par_acc <= ((^shreg) ^ bit_val) != ODD_PAR;
          if (wrap) state <= S_STOP;
        end
        S_STOP: begin
          if (bit_tick) begin
            if (stop_cnt == LAST_STOP) begin
              // Finish at the centre of the last stop bit so a back-to-back start is seen.
              state    <= S_IDLE;
              busy_o   <= 1'b0;
              baud_cnt <= '0;
              if (!valid_o || ready_i) begin
                data_o       <= shreg;
                parity_err_o <= par_acc;
                frame_err_o  <= frame_acc | ~bit_val;
                valid_o      <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              frame_acc <= frame_acc | ~bit_val;
            end
          end else if (wrap) begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
